mem_port_arbiter: RTL

Sequences and shares the single data-memory port between the pipeline's load/store path (driven by the decoder's selMEMRD/selMEMWR) and the kernel cache unit (driven by selCACHEWR/selCACHESH). It is a request/done handshake controller: it picks one requester, issues one memory transaction, waits for the memory to respond, and returns the read data. It stalls the pipeline while a load/store is outstanding. It sits between the MEM stage, the kernel cache unit, and the data memory.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// memarb_pkg: shared FSM state type, requester IDs and default timeout for mem_port_arbiter.
// Rev 1.0
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ_LS = 1'b0;
  localparam logic REQ_CC = 1'b1;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
// rr_pick2: combinational 2-way round-robin selector; on a tie the requester not granted last wins.
// Rev 1.0
module rr_pick2
  import memarb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    if (&req)
      gnt_id = ~last;
    else if (req[REQ_LS])
      gnt_id = REQ_LS;
    else
      gnt_id = REQ_CC;
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one data-memory port between load/store (0) and cache unit (1) via req/done.
// Optional BUSY abort after TIMEOUT cycles when MEMARB_TIMEOUT_EN is defined. Rev 1.0
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int BUS = 32
`ifdef MEMARB_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ls_req,
  input  logic           ls_we,
  input  logic [BUS-1:0] ls_addr,
  input  logic [BUS-1:0] ls_wdata,
  output logic           ls_done,
  output logic           ls_err,
  input  logic           cc_req,
  input  logic           cc_we,
  input  logic [BUS-1:0] cc_addr,
  input  logic [BUS-1:0] cc_wdata,
  output logic           cc_done,
  output logic           cc_err,
  output logic [BUS-1:0] rdata,
  output logic           stall,
  output logic           mem_req,
  output logic           mem_we,
  output logic [BUS-1:0] mem_addr,
  output logic [BUS-1:0] mem_wdata,
  input  logic           mem_ready,
  input  logic [BUS-1:0] mem_rdata
);

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           ptr_q, ptr_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [BUS-1:0] mem_addr_q, mem_addr_d;
  logic [BUS-1:0] mem_wdata_q, mem_wdata_d;
  logic [BUS-1:0] rdata_q, rdata_d;
  logic           ls_done_q, ls_done_d;
  logic           cc_done_q, cc_done_d;
  logic           gnt_valid;
  logic           gnt_id;

`ifdef MEMARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ls_err_q, ls_err_d;
  logic             cc_err_q, cc_err_d;
`endif

  rr_pick2 u_pick (
    .req       ({cc_req, ls_req}),
    .last      (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ls_done_d   = 1'b0;
    cc_done_d   = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    ls_err_d    = 1'b0;
    cc_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d     = gnt_id;
          mem_req_d   = 1'b1;
          mem_we_d    = (gnt_id == REQ_CC) ? cc_we    : ls_we;
          mem_addr_d  = (gnt_id == REQ_CC) ? cc_addr  : ls_addr;
          mem_wdata_d = (gnt_id == REQ_CC) ? cc_wdata : ls_wdata;
          state_d     = BUSY;
`ifdef MEMARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          ls_done_d = (owner_q == REQ_LS);
          cc_done_d = (owner_q == REQ_CC);
          state_d   = DONE;
        end
`ifdef MEMARB_TIMEOUT_EN
        // The last silent BUSY cycle aborts the transfer with a zeroed read.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d   = '0;
          mem_req_d = 1'b0;
          ls_done_d = (owner_q == REQ_LS);
          cc_done_d = (owner_q == REQ_CC);
          ls_err_d  = (owner_q == REQ_LS);
          cc_err_d  = (owner_q == REQ_CC);
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= REQ_LS;
      ptr_q       <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ls_done_q   <= 1'b0;
      cc_done_q   <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
      cnt_q       <= '0;
      ls_err_q    <= 1'b0;
      cc_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ls_done_q   <= ls_done_d;
      cc_done_q   <= cc_done_d;
`ifdef MEMARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      ls_err_q    <= ls_err_d;
      cc_err_q    <= cc_err_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign ls_done   = ls_done_q;
  assign cc_done   = cc_done_q;
  assign stall     = ls_req && !ls_done_q;

`ifdef MEMARB_TIMEOUT_EN
  assign ls_err = ls_err_q;
  assign cc_err = cc_err_q;
`else
  assign ls_err = 1'b0;
  assign cc_err = 1'b0;
`endif

endmodule
`default_nettype wire
